// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encodings and
// the width of the completed-frame counter.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PARITY  = 2'd2
  } state_e;

  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/serial_frame_rx_shift_reg.sv
// Generic MSB-first shift register: new bits enter at the LSB, with a
// synchronous reload and an asynchronous clear, both to CLR_VAL.
module frame_shift_reg #(
  parameter int            N       = 8,
  parameter logic [N-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         sync_clr,
  input  logic         din,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Reload takes priority over shifting so a frame end always re-arms the window.
  always_comb begin
    q_d = q_q;
    if (sync_clr) begin
      q_d = CLR_VAL;
    end else if (shift_en) begin
      q_d = {q_q[N-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= CLR_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, collects WIDTH data bits
// plus one even-parity bit, and presents the word with a one-cycle VALID.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int                 WIDTH    = 8,
  parameter int                 SYNC_W   = 8,
  parameter logic [SYNC_W-1:0]  SYNC_PAT = 8'hA5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SIN,
  input  logic                   EN,
  output logic [WIDTH-1:0]       DATA,
  output logic                   VALID,
  output logic                   PERR,
  output logic                   LOCKED,
  output logic [FRAME_CNT_W-1:0] FRAMES
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    perr_q, perr_d;
  logic                    locked_q, locked_d;
  logic [FRAME_CNT_W-1:0]  frames_q, frames_d;

  logic [SYNC_W-1:0]       win;
  logic [SYNC_W-1:0]       win_next;
  logic [WIDTH-1:0]        word;
  logic                    win_shift;
  logic                    win_clr;
  logic                    data_shift;

  assign win_next   = {win[SYNC_W-2:0], SIN};
  assign win_shift  = EN && (state_q == ST_HUNT);
  assign win_clr    = EN && (state_q == ST_PARITY);
  assign data_shift = EN && (state_q == ST_COLLECT);

  // The window only moves while hunting, so sync-like payload cannot resync.
  frame_shift_reg #(
    .N       (SYNC_W),
    .CLR_VAL (~SYNC_PAT)
  ) u_sync_win (
    .clk      (CLK),
    .rst_n    (RESET),
    .shift_en (win_shift),
    .sync_clr (win_clr),
    .din      (SIN),
    .q        (win)
  );

  frame_shift_reg #(
    .N       (WIDTH),
    .CLR_VAL ('0)
  ) u_data_sr (
    .clk      (CLK),
    .rst_n    (RESET),
    .shift_en (data_shift),
    .sync_clr (1'b0),
    .din      (SIN),
    .q        (word)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_HUNT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HUNT: begin
        if (EN && (win_next == SYNC_PAT)) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (EN) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (EN) begin
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Word, parity and frame count are all committed on the parity edge.
  always_comb begin
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    frames_d = frames_q;
    locked_d = (state_d == ST_COLLECT) || (state_d == ST_PARITY);
    if (EN && (state_q == ST_PARITY)) begin
      data_d   = word;
      valid_d  = 1'b1;
      perr_d   = (^word) ^ SIN;
      frames_d = frames_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      locked_q <= 1'b0;
      frames_q <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      locked_q <= locked_d;
      frames_q <= frames_d;
    end
  end

  assign DATA   = data_q;
  assign VALID  = valid_q;
  assign PERR   = perr_q;
  assign LOCKED = locked_q;
  assign FRAMES = frames_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: expected words are queued as frames are
// sent and a negedge monitor pops and compares them whenever VALID is seen.
module tb_serial_frame_rx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SIN = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] DATA;
  logic       VALID;
  logic       PERR;
  logic       LOCKED;
  logic [7:0] FRAMES;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic [7:0] frames;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   fails = 0;
  bit   gated = 1'b0;

  serial_frame_rx #(
    .WIDTH    (8),
    .SYNC_W   (8),
    .SYNC_PAT (8'hA5)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .SIN    (SIN),
    .EN     (EN),
    .DATA   (DATA),
    .VALID  (VALID),
    .PERR   (PERR),
    .LOCKED (LOCKED),
    .FRAMES (FRAMES)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // In gated mode every enabled bit is preceded by an idle EN=0 cycle.
  task automatic applyStimulus(input logic b);
    if (gated) begin
      @(negedge CLK);
      EN  = 1'b0;
      SIN = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    EN  = 1'b1;
    SIN = b;
  endtask

  task automatic sendBits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(v[i]);
    end
  endtask

  task automatic runFrame(input logic [7:0] d, input logic par,
                          input logic expPerr, input logic [7:0] expFrames);
    logic [7:0] syncPat;
    syncPat = 8'hA5;
    expQ.push_back('{data: d, perr: expPerr, frames: expFrames});
    for (int i = 7; i >= 1; i--) begin
      applyStimulus(syncPat[i]);
    end
    @(posedge CLK); #1;
    checkOutput("locked_before_sync_end", LOCKED, 0);
    applyStimulus(syncPat[0]);
    @(posedge CLK); #1;
    checkOutput("locked_after_sync", LOCKED, 1);
    sendBits(d, 8);
    applyStimulus(par);
    @(posedge CLK); #1;
    checkOutput("valid_at_17th_edge", VALID, 1);
    checkOutput("locked_after_parity", LOCKED, 0);
    checkOutput("frames_count", FRAMES, expFrames);
    @(negedge CLK);
    EN  = 1'b0;
    SIN = 1'b0;
    @(posedge CLK); #1;
    checkOutput("valid_one_cycle", VALID, 0);
    checkOutput("data_hold", DATA, d);
  endtask

  always @(negedge CLK) begin
    if (RESET === 1'b1 && VALID === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("sb_data", DATA, monE.data);
        checkOutput("sb_perr", PERR, monE.perr);
        checkOutput("sb_frames", FRAMES, monE.frames);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b0;
    EN    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      SIN = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      checkOutput("rst_data", DATA, 0);
      checkOutput("rst_valid", VALID, 0);
      checkOutput("rst_perr", PERR, 0);
      checkOutput("rst_locked", LOCKED, 0);
      checkOutput("rst_frames", FRAMES, 0);
    end
    @(negedge CLK);
    RESET = 1'b1;
    EN    = 1'b0;

    // 3C has four ones, so parity 0 is correct and parity 1 is an error.
    runFrame(8'h3C, 1'b0, 1'b0, 8'd1);
    runFrame(8'h3C, 1'b1, 1'b1, 8'd2);

    sendBits(8'hF5, 8);
    @(posedge CLK); #1;
    checkOutput("noise_no_lock", LOCKED, 0);
    runFrame(8'hA5, 1'b0, 1'b0, 8'd3);
    runFrame(8'h01, 1'b1, 1'b0, 8'd4);

    gated = 1'b1;
    runFrame(8'h3C, 1'b0, 1'b0, 8'd5);
    gated = 1'b0;

    sendBits(8'hA5, 8);
    sendBits(8'h0C, 4);
    @(posedge CLK); #1;
    checkOutput("locked_mid_frame", LOCKED, 1);
    @(negedge CLK);
    EN    = 1'b0;
    RESET = 1'b0;
    #1;
    checkOutput("midrst_locked", LOCKED, 0);
    checkOutput("midrst_valid", VALID, 0);
    checkOutput("midrst_frames", FRAMES, 0);
    checkOutput("midrst_data", DATA, 0);
    @(negedge CLK);
    RESET = 1'b1;
    // The aborted frame never counted, and reset itself returns FRAMES to 0.
    runFrame(8'hC3, 1'b0, 1'b0, 8'd1);

    repeat (3) @(negedge CLK);
    checkOutput("sb_queue_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
